// File: rtl/axi_rd_arbiter_2m_if.sv
// AXI4 read-channel bundle (AR + R) shared by the arbiter's two master
// ports and its single slave port.
interface axi_rd_arbiter_2m_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] rd_addr_id;
  logic [31:0]         rd_addr;
  logic [7:0]          rd_addr_len;
  logic [1:0]          rd_addr_burst;
  logic                rd_addr_valid;
  logic                rd_addr_ready;
  logic [ID_WIDTH-1:0] rd_back_id;
  logic [31:0]         rd_data;
  logic [1:0]          rd_data_resp;
  logic                rd_data_last;
  logic                rd_data_valid;
  logic                rd_data_ready;

  // Issuer of read requests: drives AR and R ready.
  modport master (
    output rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    output rd_data_ready,
    input  rd_addr_ready,
    input  rd_back_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid
  );

  // Responder to read requests: drives AR ready and the R channel.
  modport slave (
    input  rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    input  rd_data_ready,
    output rd_addr_ready,
    output rd_back_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid
  );
endinterface

// File: rtl/axi_rd_arbiter_2m.sv
// Two-master, one-slave AXI4 read arbiter: one burst outstanding at a time,
// round-robin grant, R beats counted against AR LEN to flag length errors.
module axi_rd_arbiter_2m #(
  parameter int ID_WIDTH = 4
) (
  input  logic                      BUS_CLK,
  input  logic                      BUS_RSTN,
  axi_rd_arbiter_2m_if.slave        m0,
  axi_rd_arbiter_2m_if.slave        m1,
  axi_rd_arbiter_2m_if.master       s,
  output logic                      GRANT,
  output logic                      BUSY,
  output logic                      LEN_ERR,
  output logic                      LEN_ERR_STICKY,
  output logic [1:0]                STATE_DBG
);

  // Handshakes: a transfer happens on a rising edge where VALID and READY are
  // both high; VALID never waits on READY, and READY may depend on VALID.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [8:0]  remaining_q, remaining_d;
  logic        len_err_q, len_err_d;
  logic        sticky_q, sticky_d;

  logic                sel_ar_valid;
  logic [7:0]          sel_ar_len;
  logic                sel_r_ready;
  logic [ID_WIDTH-1:0] sel_ar_id;
  logic                ar_hs;
  logic                r_hs;
  logic                in_addr;
  logic                in_data;

  // Selection only depends on the registered grant, so no master input can
  // reach the other master's outputs combinationally.
  assign sel_ar_valid = grant_q ? m1.rd_addr_valid : m0.rd_addr_valid;
  assign sel_ar_len   = grant_q ? m1.rd_addr_len   : m0.rd_addr_len;
  assign sel_ar_id    = grant_q ? m1.rd_addr_id    : m0.rd_addr_id;
  assign sel_r_ready  = grant_q ? m1.rd_data_ready : m0.rd_data_ready;

  assign in_addr = (state_q == ST_ADDR);
  assign in_data = (state_q == ST_DATA);
  assign ar_hs   = in_addr && sel_ar_valid && s.rd_addr_ready;
  assign r_hs    = in_data && s.rd_data_valid && sel_r_ready;

  always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
    if (!BUS_RSTN) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      remaining_q  <= 9'd0;
      len_err_q    <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      len_err_q    <= len_err_d;
      sticky_q     <= sticky_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    len_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0.rd_addr_valid || m1.rd_addr_valid) begin
          grant_d = (m0.rd_addr_valid && m1.rd_addr_valid) ? ~last_grant_q
                                                            : m1.rd_addr_valid;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          remaining_d = {1'b0, sel_ar_len};
          state_d     = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          remaining_d = (remaining_q == 9'd0) ? 9'd0 : remaining_q - 9'd1;
          // remaining counts beats still owed after this one.
          len_err_d   = s.rd_data_last ? (remaining_q != 9'd0)
                                       : (remaining_q == 9'd0);
          if (s.rd_data_last) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    sticky_d = sticky_q | len_err_d;
  end

  // Slave-side AR: fields always follow the granted master, VALID only in ADDR.
  assign s.rd_addr_id    = sel_ar_id;
  assign s.rd_addr       = grant_q ? m1.rd_addr       : m0.rd_addr;
  assign s.rd_addr_len   = sel_ar_len;
  assign s.rd_addr_burst = grant_q ? m1.rd_addr_burst : m0.rd_addr_burst;
  assign s.rd_addr_valid = in_addr && sel_ar_valid;
  assign s.rd_data_ready = in_data && sel_r_ready;

  assign m0.rd_addr_ready = in_addr && !grant_q && s.rd_addr_ready;
  assign m1.rd_addr_ready = in_addr &&  grant_q && s.rd_addr_ready;

  assign m0.rd_back_id   = s.rd_back_id;
  assign m0.rd_data      = s.rd_data;
  assign m0.rd_data_resp = s.rd_data_resp;
  assign m0.rd_data_valid = in_data && !grant_q && s.rd_data_valid;
  assign m0.rd_data_last  = in_data && !grant_q && s.rd_data_last;

  assign m1.rd_back_id   = s.rd_back_id;
  assign m1.rd_data      = s.rd_data;
  assign m1.rd_data_resp = s.rd_data_resp;
  assign m1.rd_data_valid = in_data &&  grant_q && s.rd_data_valid;
  assign m1.rd_data_last  = in_data &&  grant_q && s.rd_data_last;

  assign GRANT          = grant_q;
  assign BUSY           = (state_q != ST_IDLE);
  assign LEN_ERR        = len_err_q;
  assign LEN_ERR_STICKY = sticky_q;
  assign STATE_DBG      = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter_2m.sv
// Directed bench for axi_rd_arbiter_2m: table of single-master bursts plus
// hand-written contention and mid-burst reset sequences.
module tb_axi_rd_arbiter_2m;
  localparam int IDW = 4;

  logic       clk;
  logic       rst_n;
  logic       grant, busy, len_err, len_err_sticky;
  logic [1:0] state_dbg;

  axi_rd_arbiter_2m_if #(.ID_WIDTH(IDW)) m0_if ();
  axi_rd_arbiter_2m_if #(.ID_WIDTH(IDW)) m1_if ();
  axi_rd_arbiter_2m_if #(.ID_WIDTH(IDW)) s_if ();

  axi_rd_arbiter_2m #(.ID_WIDTH(IDW)) dut (
    .BUS_CLK        (clk),
    .BUS_RSTN       (rst_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .s              (s_if),
    .GRANT          (grant),
    .BUSY           (busy),
    .LEN_ERR        (len_err),
    .LEN_ERR_STICKY (len_err_sticky),
    .STATE_DBG      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_ar(input logic mst, input logic v, input logic [IDW-1:0] id,
                          input logic [31:0] addr, input logic [7:0] len);
    if (!mst) begin
      m0_if.rd_addr_valid = v; m0_if.rd_addr_id = id; m0_if.rd_addr = addr;
      m0_if.rd_addr_len = len; m0_if.rd_addr_burst = 2'b01;
    end else begin
      m1_if.rd_addr_valid = v; m1_if.rd_addr_id = id; m1_if.rd_addr = addr;
      m1_if.rd_addr_len = len; m1_if.rd_addr_burst = 2'b01;
    end
  endtask

  task automatic set_rready(input logic mst, input logic r);
    if (!mst) m0_if.rd_data_ready = r;
    else      m1_if.rd_data_ready = r;
  endtask

  task automatic drive_r(input logic v, input logic [IDW-1:0] id,
                         input logic [31:0] data, input logic last);
    s_if.rd_data_valid = v;
    s_if.rd_back_id    = id;
    s_if.rd_data       = data;
    s_if.rd_data_resp  = 2'b00;
    s_if.rd_data_last  = last;
  endtask

  function automatic logic get_rvalid(input logic mst);
    return mst ? m1_if.rd_data_valid : m0_if.rd_data_valid;
  endfunction
  function automatic logic get_rlast(input logic mst);
    return mst ? m1_if.rd_data_last : m0_if.rd_data_last;
  endfunction
  function automatic logic [31:0] get_rdata(input logic mst);
    return mst ? m1_if.rd_data : m0_if.rd_data;
  endfunction
  function automatic logic [IDW-1:0] get_rid(input logic mst);
    return mst ? m1_if.rd_back_id : m0_if.rd_back_id;
  endfunction
  function automatic logic get_arready(input logic mst);
    return mst ? m1_if.rd_addr_ready : m0_if.rd_addr_ready;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic           mst;
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic [7:0]     len;
    int             last_beat;   // beat index where the slave raises LAST
    logic           bp;          // master toggles R ready every cycle
    int             exp_beats;
    int             err_beat;    // beat whose handshake raises LEN_ERR, -1 none
    logic           exp_sticky;
  } vec_t;

  vec_t vecs[5];

  // Entered and left on a negedge with the arbiter idle.
  task automatic do_burst(input vec_t t, input int n);
    logic rdy, tog, done, hs_err, hs_last;
    int   b, guard;
    string tag;
    tag = $sformatf("v%0d", n);
    for (int i = 0; i < t.exp_beats; i++) exp_q.push_back(t.addr + 32'(4 * i));

    drive_ar(t.mst, 1'b1, t.id, t.addr, t.len);
    #1;
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_s_arvalid"}, s_if.rd_addr_valid, 1'b0);

    @(negedge clk);
    check({tag, "_s_arvalid"}, s_if.rd_addr_valid, 1'b1);
    check({tag, "_grant"}, grant, t.mst);
    check({tag, "_s_araddr"}, s_if.rd_addr, t.addr);
    check({tag, "_s_arid"}, s_if.rd_addr_id, t.id);
    check({tag, "_s_arlen"}, s_if.rd_addr_len, t.len);
    s_if.rd_addr_ready = 1'b1;
    #1;
    check({tag, "_arready_own"}, get_arready(t.mst), 1'b1);
    check({tag, "_arready_other"}, get_arready(!t.mst), 1'b0);

    @(negedge clk);
    drive_ar(t.mst, 1'b0, '0, '0, '0);
    s_if.rd_addr_ready = 1'b0;
    check({tag, "_data_busy"}, busy, 1'b1);

    b = 0; tog = 1'b1; done = 1'b0; guard = 0;
    while (!done && guard < 64) begin
      drive_r(1'b1, t.id, t.addr + 32'(4 * b), (b == t.last_beat));
      rdy = t.bp ? tog : 1'b1;
      tog = ~tog;
      set_rready(t.mst, rdy);
      #1;
      check({tag, "_rvalid_own"}, get_rvalid(t.mst), 1'b1);
      check({tag, "_rvalid_other"}, get_rvalid(!t.mst), 1'b0);
      check({tag, "_s_rready"}, s_if.rd_data_ready, rdy);
      hs_err = 1'b0; hs_last = 1'b0;
      if (rdy) begin
        if (exp_q.size() == 0) check({tag, "_extra_beat"}, 1, 0);
        else check({tag, "_rdata"}, get_rdata(t.mst), exp_q.pop_front());
        check({tag, "_rid"}, get_rid(t.mst), t.id);
        check({tag, "_rlast"}, get_rlast(t.mst), (b == t.last_beat));
        hs_err  = (b == t.err_beat);
        hs_last = (b == t.last_beat);
        b++;
      end
      @(negedge clk);
      check({tag, "_len_err"}, len_err, hs_err);
      if (hs_last) done = 1'b1;
      guard++;
    end
    if (!done) check({tag, "_burst_timeout"}, 1, 0);
    drive_r(1'b0, '0, '0, 1'b0);
    set_rready(t.mst, 1'b0);
    #1;
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_sticky"}, len_err_sticky, t.exp_sticky);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_len_err_clear"}, len_err, 1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic exp_m;
    int   guard;

    vecs[0] = '{mst:1'b0, id:4'h5, addr:32'h10,  len:8'd3, last_beat:3, bp:1'b0,
                exp_beats:4, err_beat:-1, exp_sticky:1'b0};
    vecs[1] = '{mst:1'b1, id:4'hA, addr:32'h200, len:8'd7, last_beat:7, bp:1'b1,
                exp_beats:8, err_beat:-1, exp_sticky:1'b0};
    vecs[2] = '{mst:1'b0, id:4'h3, addr:32'h300, len:8'd3, last_beat:1, bp:1'b0,
                exp_beats:2, err_beat:1,  exp_sticky:1'b1};
    vecs[3] = '{mst:1'b1, id:4'hC, addr:32'h400, len:8'd0, last_beat:1, bp:1'b0,
                exp_beats:2, err_beat:0,  exp_sticky:1'b1};
    vecs[4] = '{mst:1'b0, id:4'h0, addr:32'h500, len:8'd0, last_beat:0, bp:1'b0,
                exp_beats:1, err_beat:-1, exp_sticky:1'b1};

    // Reset state, with hostile inputs that must not leak through.
    rst_n = 1'b0;
    drive_ar(1'b0, 1'b1, 4'h1, 32'h0, 8'd0);
    drive_ar(1'b1, 1'b1, 4'h2, 32'h0, 8'd0);
    set_rready(1'b0, 1'b1);
    set_rready(1'b1, 1'b1);
    s_if.rd_addr_ready = 1'b1;
    drive_r(1'b1, 4'h1, 32'hDEAD, 1'b1);
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_sticky", len_err_sticky, 1'b0);
    check("rst_s_arvalid", s_if.rd_addr_valid, 1'b0);
    check("rst_s_rready", s_if.rd_data_ready, 1'b0);
    check("rst_m0_arready", m0_if.rd_addr_ready, 1'b0);
    check("rst_m1_arready", m1_if.rd_addr_ready, 1'b0);
    check("rst_m0_rvalid", m0_if.rd_data_valid, 1'b0);
    check("rst_m1_rvalid", m1_if.rd_data_valid, 1'b0);
    drive_ar(1'b0, 1'b0, '0, '0, '0);
    drive_ar(1'b1, 1'b0, '0, '0, '0);
    set_rready(1'b0, 1'b0);
    set_rready(1'b1, 1'b0);
    s_if.rd_addr_ready = 1'b0;
    drive_r(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_burst(vecs[i], i);

    // Reset during beat 2 of a 4-beat M0 burst (last_grant is 0 beforehand).
    drive_ar(1'b0, 1'b1, 4'h7, 32'h600, 8'd3);
    @(negedge clk);
    s_if.rd_addr_ready = 1'b1;
    @(negedge clk);
    s_if.rd_addr_ready = 1'b0;
    drive_ar(1'b0, 1'b0, '0, '0, '0);
    set_rready(1'b0, 1'b1);
    drive_r(1'b1, 4'h7, 32'h600, 1'b0);
    @(negedge clk);
    drive_r(1'b1, 4'h7, 32'h604, 1'b0);
    #1;
    check("mid_rvalid_before_rst", m0_if.rd_data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m0_rvalid", m0_if.rd_data_valid, 1'b0);
    check("mid_rst_m1_rvalid", m1_if.rd_data_valid, 1'b0);
    check("mid_rst_s_rready", s_if.rd_data_ready, 1'b0);
    check("mid_rst_s_arvalid", s_if.rd_addr_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sticky", len_err_sticky, 1'b0);
    drive_r(1'b0, '0, '0, 1'b0);
    set_rready(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention, both held: service order M0, M1, M0, M1, 2 beats each.
    drive_ar(1'b0, 1'b1, 4'h1, 32'h1000, 8'd1);
    drive_ar(1'b1, 1'b1, 4'h2, 32'h2000, 8'd1);
    set_rready(1'b0, 1'b1);
    set_rready(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      exp_m = (k % 2 == 1);
      @(negedge clk);
      guard = 0;
      while (!s_if.rd_addr_valid && guard < 8) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("cont%0d_arvalid", k), s_if.rd_addr_valid, 1'b1);
      check($sformatf("cont%0d_grant", k), grant, exp_m);
      check($sformatf("cont%0d_arid", k), s_if.rd_addr_id, exp_m ? 4'h2 : 4'h1);
      s_if.rd_addr_ready = 1'b1;
      #1;
      check($sformatf("cont%0d_arready_own", k), get_arready(exp_m), 1'b1);
      check($sformatf("cont%0d_arready_other", k), get_arready(!exp_m), 1'b0);
      @(negedge clk);
      s_if.rd_addr_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
        drive_r(1'b1, exp_m ? 4'h2 : 4'h1, 32'hC000 + 32'(k * 16 + b), (b == 1));
        #1;
        check($sformatf("cont%0d_b%0d_rvalid_own", k, b), get_rvalid(exp_m), 1'b1);
        check($sformatf("cont%0d_b%0d_rvalid_other", k, b), get_rvalid(!exp_m), 1'b0);
        check($sformatf("cont%0d_b%0d_rdata", k, b), get_rdata(exp_m),
              32'hC000 + 32'(k * 16 + b));
        @(negedge clk);
      end
      drive_r(1'b0, '0, '0, 1'b0);
      #1;
      check($sformatf("cont%0d_end_busy", k), busy, 1'b0);
    end
    drive_ar(1'b0, 1'b0, '0, '0, '0);
    drive_ar(1'b1, 1'b0, '0, '0, '0);
    check("cont_sticky", len_err_sticky, 1'b0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter_2m.md
Name: axi_rd_arbiter_2m

Overview:
- Two-master, one-slave AXI4 read-channel arbiter. Shares one slave (for example the simulation slave memory or the DDR read port) between two masters.
- Only one burst is outstanding at a time. Grants are round-robin.
- Counts R beats against the AR LEN and flags slave-side burst-length violations.
- Placed in the interconnect between the master read ports and the slave read port.

Parameters:
ID_WIDTH, 4, width of the RD_ADDR_ID and RD_BACK_ID fields. IDs pass through unchanged.

Ports:
BUS_CLK  in  1  single clock for all channels
BUS_RSTN  in  1  reset, asynchronous, active-low
Mx_RD_ADDR_ID (x=0,1)  in  ID_WIDTH  master AR ID
Mx_RD_ADDR  in  32  master AR address
Mx_RD_ADDR_LEN  in  8  master AR length (beats-1)
Mx_RD_ADDR_BURST  in  2  master AR burst type
Mx_RD_ADDR_VALID  in  1  master AR valid
Mx_RD_ADDR_READY  out  1  master AR ready
Mx_RD_BACK_ID  out  ID_WIDTH  R ID to master
Mx_RD_DATA  out  32  R data to master
Mx_RD_DATA_RESP  out  2  R response to master
Mx_RD_DATA_LAST  out  1  R last to master
Mx_RD_DATA_VALID  out  1  R valid to master
Mx_RD_DATA_READY  in  1  R ready from master
S_RD_ADDR_ID/S_RD_ADDR/S_RD_ADDR_LEN/S_RD_ADDR_BURST  out  ID_WIDTH/32/8/2  AR fields to slave
S_RD_ADDR_VALID  out  1  AR valid to slave
S_RD_ADDR_READY  in  1  AR ready from slave
S_RD_BACK_ID/S_RD_DATA/S_RD_DATA_RESP/S_RD_DATA_LAST  in  ID_WIDTH/32/2/1  R fields from slave
S_RD_DATA_VALID  in  1  R valid from slave
S_RD_DATA_READY  out  1  R ready to slave
GRANT  out  1  index of the current or last granted master
BUSY  out  1  high in ADDR or DATA state
LEN_ERR  out  1  one-cycle pulse on a beat-count mismatch
LEN_ERR_STICKY  out  1  latched LEN_ERR; cleared only by reset

Behaviour:
- Reset (async, BUS_RSTN=0):
  - state=IDLE, GRANT=0, last_grant=1 (M0 wins first), beat counter=0.
  - All VALID and READY outputs 0; BUSY, LEN_ERR and LEN_ERR_STICKY 0.
  - Data, ID and field outputs may be 0 or pass-through; they are don't-care while VALID=0.
- Reset mid-burst: immediate return to IDLE with all handshakes deasserted. The slave must also be reset.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If exactly one Mx_RD_ADDR_VALID is high, grant it.
  - If both are high, grant !last_grant.
  - GRANT is registered. Move to ADDR on the next edge, so there is 1 cycle of arbitration latency.
  - No READY or VALID is asserted in IDLE.
- ADDR:
  - S_RD_ADDR_* and S_RD_ADDR_VALID are combinational muxes of M[GRANT].
  - M[GRANT]_RD_ADDR_READY = S_RD_ADDR_READY. The other master's READY is 0.
  - State is held until the handshake. If the master drops VALID (protocol violation), stay in ADDR with no timeout.
  - On handshake: remaining=LEN (9-bit), then go to DATA.
- DATA:
  - M[GRANT]_RD_* = S_RD_*, and S_RD_DATA_READY = M[GRANT]_RD_DATA_READY.
  - The non-granted master sees VALID=0 and LAST=0.
  - On each R handshake, remaining decrements, saturating at 0.
  - Mismatch: LAST=1 with remaining!=0, or LAST=0 with remaining==0. Either sets the LEN_ERR pulse (next cycle) and LEN_ERR_STICKY.
  - The beat is still forwarded. The burst ends only on a handshake with S_RD_DATA_LAST=1; then last_grant=GRANT and go to IDLE.
- No new AR is accepted while BUSY. There are no combinational paths from an Mx input to the other master's outputs.
- Throughput: back-to-back bursts incur 1 idle cycle (IDLE) plus the AR handshake cycle.

Test Plan:
1. Single master: M0 reads ADDR=0x10, LEN=3, ID=5, slave ready immediately -> S_RD_ADDR_VALID rises 1 cycle after M0 VALID; M0 receives 4 beats with ID=5 and LAST on beat 4; M1 VALID stays 0; GRANT=0; LEN_ERR_STICKY=0.
2. Contention: M0 and M1 assert AR in the same cycle, each LEN=1, held asserted -> order of service is M0, M1, M0, M1; each burst is 2 beats; no beats are interleaved.
3. Backpressure: M1 toggles RD_DATA_READY 1/0 every cycle over a LEN=7 burst -> S_RD_DATA_READY mirrors it; 8 beats are delivered in order with no loss or duplication.
4. Early LAST: slave asserts LAST on beat 2 of a LEN=3 burst -> LEN_ERR pulses once; sticky=1; FSM returns to IDLE; next AR is granted normally.
5. Missing LAST: LEN=0 and the slave sends beat 1 without LAST, then a LAST beat -> LEN_ERR on beat 1; burst ends on the second beat.
6. Async reset asserted mid-DATA (beat 2 of 4) -> all VALID and READY outputs are 0 within the same cycle; BUSY=0; after release, M0 has priority (last_grant=1).
